// File: rtl/dmem_seq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_seq_pkg
// Purpose  : Shared types and sizing for the byte-wide data memory sequencer.
// Revision : 1.0
// ============================================================================
package dmem_seq_pkg;

  localparam int DMEM_AW    = 13;
  localparam int DMEM_DW    = 64;
  localparam int DMEM_BEATS = DMEM_DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dmem_state_e;

  // Width of a beat index; a single-beat bus still needs one bit.
  function automatic int beat_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_seq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_seq_arbiter_if
// Purpose  : Requester ports, completion signals and byte-memory bus.
// Revision : 1.0
// ============================================================================
interface dmem_seq_arbiter_if
  import dmem_seq_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, err, busy, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, err, busy, mem_addr, mem_we, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_seq_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter; owns the last-grant history bit.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic r_last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (grant_en && (|req)) begin
      r_last_grant <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_seq_arbiter
// Purpose  : Round-robin two-port arbiter sequencing doubleword loads/stores
//            as little-endian byte beats. Optional misalignment rejection via
//            macro DMEM_SEQ_ARBITER_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
module dmem_seq_arbiter
  import dmem_seq_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_seq_arbiter_if.slave  bus
);

  localparam int             BEATS       = DW / 8;
  localparam int             BW          = beat_bits(BEATS);
  localparam logic [BW-1:0]  c_last_beat = BW'(BEATS - 1);

  dmem_state_e   r_state;
  dmem_state_e   w_next_state;

  logic [1:0]    w_gnt;
  logic          w_accept;
  logic          w_sel_port;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_misaligned;

  logic [BW-1:0] r_beat;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_port;
  logic          r_cap_vld;
  logic [BW-1:0] r_cap_idx;
  logic [DW-1:0] r_rdata;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({bus.req1, bus.req0}),
    .grant_en (r_state == IDLE),
    .gnt      (w_gnt)
  );

  assign w_accept    = (r_state == IDLE) && (|w_gnt);
  assign w_sel_port  = w_gnt[1];
  assign w_sel_we    = w_sel_port ? bus.we1    : bus.we0;
  assign w_sel_addr  = w_sel_port ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_sel_port ? bus.wdata1 : bus.wdata0;

`ifdef DMEM_SEQ_ARBITER_ALIGN_CHECK_EN
  logic r_err;

  assign w_misaligned = (w_sel_addr[BW-1:0] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misaligned;
    end
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and memory/handshake outputs
  always_comb begin
    w_next_state  = r_state;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.ack0      = 1'b0;
    bus.ack1      = 1'b0;
    bus.err       = 1'b0;
    bus.busy      = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_misaligned ? DONE : XFER;
        end
      end
      XFER: begin
        bus.mem_addr = r_addr + AW'(r_beat);
        if (r_we) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = r_wdata[8*r_beat +: 8];
        end
        if (r_beat == c_last_beat) begin
          w_next_state = r_we ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        w_next_state = DONE;
      end
      DONE: begin
        bus.ack0     = ~r_port;
        bus.ack1     = r_port;
`ifdef DMEM_SEQ_ARBITER_ALIGN_CHECK_EN
        bus.err      = r_err;
`endif
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request latch, beat counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_port    <= 1'b0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_port  <= w_sel_port;
        r_beat  <= '0;
      end else if (r_state == XFER) begin
        r_beat <= r_beat + 1'b1;
      end

      // Memory returns a byte one cycle after its address, so capture lags a beat.
      r_cap_vld <= (r_state == XFER) && !r_we;
      r_cap_idx <= r_beat;
      if (r_cap_vld) begin
        r_rdata[8*r_cap_idx +: 8] <= bus.mem_rdata;
      end
    end
  end

  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_seq_arbiter.md
# dmem_seq_arbiter

Sequencing controller and two-port arbiter for the byte-wide data memory (8192 bytes, 64-bit doublewords). It accepts doubleword load/store requests from two requesters: port 0 is the MemoryAccess-stage data port and port 1 is the loader/debug port. It arbitrates round-robin between them and sequences each granted request as eight single-byte memory beats in little-endian order. Read data is returned with a one-cycle acknowledge.

## Interface
Parameters:
- AW, 13, byte address width; the memory holds 2^AW bytes.
- DW, 64, request data width; must be a multiple of 8. BEATS = DW/8 is derived.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request from port 0 / port 1; held high until that port's ack.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  AW  byte address of the doubleword.
- wdata0 / wdata1  in  DW  store data.
- ack0 / ack1  out  1  one-cycle completion pulse to the granted port.
- rdata  out  DW  load data; valid only while ack0 or ack1 is high.
- err  out  1  misaligned-request flag; valid with ack (see Configuration).
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  AW  byte address to the memory.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  byte write data.
- mem_rdata  in  8  byte read data; returned one cycle after mem_addr is presented.

## Operation
- Reset values: all outputs 0; state IDLE; last_grant = 1, so port 0 wins the first contention.
- States:
  - IDLE: when any req is high, grant a port, latch its we/addr/wdata and the port id, then go to XFER with beat = 0.
  - XFER: drive mem_addr = base + beat. For a store, also drive mem_we = 1 and mem_wdata = wdata[8*beat+7 : 8*beat]. Stores go to DONE after beat BEATS-1. Loads go to DRAIN after beat BEATS-1.
  - DRAIN (loads only): capture the last returned byte; mem_we = 0; go to DONE.
  - DONE: assert ack on the latched port for one cycle; go to IDLE.
- Load capture: the byte issued at beat k is written to rdata[8k+7 : 8k] one cycle later. rdata holds its value until the next load.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - last_grant updates on every grant.
- Requests are sampled only in IDLE. A req that is still high in the IDLE cycle after ack is a new request.
- Address arithmetic is modulo 2^AW: base + beat wraps from 8191 to 0.
- Reset asserted mid-transfer clears everything immediately: mem_we drops asynchronously. Bytes already written stay written; there is no rollback. ack is never issued for the aborted request.
- Changes to req or data on the non-granted port, or to data on the granted port, during a transfer are ignored, because the request was latched in IDLE.

## Timing
- Store: req seen in IDLE at edge T; beats occupy cycles T+1..T+8; ack is high in cycle T+9.
- Load: beats occupy T+1..T+8; DRAIN is T+9; ack and rdata are valid in T+10.
- Earliest next acceptance is the IDLE cycle after DONE. Back-to-back stores complete every 10 cycles; back-to-back loads every 11 cycles.
- A contending request waits at most one full transaction before it is granted.

## Configuration
- Macro DMEM_SEQ_ARBITER_ALIGN_CHECK_EN.
  - Defined: a request with addr[2:0] != 0 goes IDLE→DONE directly. No memory beats are issued, ack is asserted with err = 1, rdata is unchanged, and last_grant still updates.
  - Undefined: there is no check. A misaligned address runs normally with modulo wrap, and err is tied to 0.

## Structure
- Package dmem_seq_pkg: state enum (IDLE, XFER, DRAIN, DONE), DMEM_AW = 13, DMEM_DW = 64, DMEM_BEATS = 8.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], grant_en.
  - Outputs: one-hot gnt[1:0].
  - Owns the last_grant register.

## Test plan
- Store on port 0, addr 0x010, wdata 0x8877665544332211 → mem writes 0x11..0x88 to 0x010..0x017 in cycles T+1..T+8; ack0 in T+9.
- Load on port 1 from addr 0x010 after the store above → rdata = 0x8877665544332211 with ack1 in T+10; ack0 stays 0.
- req0 and req1 rise together from reset → port 0 granted first, port 1 next. Then both re-request → port 0 is granted again, because last_grant was port 1.
- Store at addr 0x1FFC with the check undefined → bytes land at 0x1FFC..0x1FFF then 0x000..0x003.
- Same request with DMEM_SEQ_ARBITER_ALIGN_CHECK_EN defined → no mem_we pulses; ack with err = 1 in T+1.
- rst_n pulled low at beat 3 of a store → mem_we = 0 immediately; only bytes 0..2 are modified; no ack; first post-reset request proceeds normally.
